// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline sequencer for the 5-stage MIPS core. It resolves load-use hazards,
// taken branches and jumps, and data-memory wait states into PC and pipeline
// register controls. It also runs the dmem req/ack handshake, including a
// wait-cycle timeout, a sticky error state and a saturating stall counter.
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_id_jump,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_ex_rt,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_access,
    input  logic             i_dmem_ack,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_memwb_bubble,
    output logic             o_dmem_req,
    output logic             o_timeout_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // Counter wide enough to hold TIMEOUT itself
    localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_ONE     = WC_W'(1);
    localparam logic [WC_W-1:0] WC_TIMEOUT = WC_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERR      = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [WC_W-1:0]  w_wait_cnt_nxt;
    logic [WC_W-1:0]  w_wait_cnt_inc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lu;
    logic             w_wait;
    logic             w_stall_evt;

    // A load in EX writing a nonzero register that the ID instruction reads
    assign w_lu = i_ex_memread && (i_ex_rt != 5'd0) &&
                  ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
    // Memory access still outstanding this cycle
    assign w_wait         = i_mem_access && !i_dmem_ack;
    assign w_wait_cnt_inc = r_wait_cnt + WC_ONE;

    // State and wait-counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic for the dmem handshake; an ack on the last allowed cycle beats the timeout
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_RUN: begin
                if (w_wait) begin
                    w_wait_cnt_nxt = WC_ONE;
                    if (WC_ONE == WC_TIMEOUT) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_MEM_WAIT;
                    end
                end else begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end
            end
            S_MEM_WAIT: begin
                if (i_dmem_ack) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = w_wait_cnt_inc;
                    if (w_wait_cnt_inc == WC_TIMEOUT) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_state_nxt = S_MEM_WAIT;
                    end
                end
            end
            S_ERR: begin
                w_state_nxt    = S_ERR;
                w_wait_cnt_nxt = r_wait_cnt;
            end
            default: begin
                w_state_nxt    = S_ERR;
                w_wait_cnt_nxt = r_wait_cnt;
            end
        endcase
    end

    // Pipeline controls by priority: reset, error, memory freeze, branch, load-use, jump, run
    always_comb begin
        o_pc_en        = 1'b1;
        o_ifid_en      = 1'b1;
        o_ifid_flush   = 1'b0;
        o_idex_en      = 1'b1;
        o_idex_flush   = 1'b0;
        o_exmem_en     = 1'b1;
        o_memwb_bubble = 1'b0;
        o_dmem_req     = 1'b0;
        o_timeout_err  = 1'b0;
        if (i_rst) begin
            o_pc_en        = 1'b0;
            o_ifid_en      = 1'b0;
            o_ifid_flush   = 1'b1;
            o_idex_en      = 1'b0;
            o_idex_flush   = 1'b1;
            o_exmem_en     = 1'b0;
            o_memwb_bubble = 1'b1;
        end else if (r_state == S_ERR) begin
            o_pc_en        = 1'b0;
            o_ifid_en      = 1'b0;
            o_idex_en      = 1'b0;
            o_exmem_en     = 1'b0;
            o_memwb_bubble = 1'b1;
            o_timeout_err  = 1'b1;
        end else begin
            o_dmem_req = i_mem_access;
            if (w_wait) begin
                // Everything is re-evaluated once the access completes
                o_pc_en        = 1'b0;
                o_ifid_en      = 1'b0;
                o_idex_en      = 1'b0;
                o_exmem_en     = 1'b0;
                o_memwb_bubble = 1'b1;
            end else if (i_ex_br_taken) begin
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
            end else if (w_lu) begin
                // Hold PC and IF/ID (and any jump in ID) for one cycle, bubble into EX
                o_pc_en      = 1'b0;
                o_ifid_en    = 1'b0;
                o_idex_flush = 1'b1;
            end else if (i_id_jump) begin
                o_ifid_flush = 1'b1;
            end else begin
                o_pc_en = 1'b1;
            end
        end
    end

    // Stall cycles outside the error state count, reset cycles are covered by the async clear
    assign w_stall_evt = !o_pc_en && (r_state != S_ERR);

    // Saturating stall performance counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl, default parameters (TIMEOUT=16, CNT_W=16).
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_jump;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        ex_br_taken;
    logic        mem_access;
    logic        dmem_ack;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_en;
    logic        idex_flush;
    logic        exmem_en;
    logic        memwb_bubble;
    logic        dmem_req;
    logic        timeout_err;
    logic [15:0] stall_cnt;

    int errors;
    int checks;
    int exp_stall;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, dmem_req, timeout_err}
    logic [8:0] ctl;
    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, dmem_req, timeout_err};

    localparam logic [8:0] V_RESET  = 9'b001010100;
    localparam logic [8:0] V_RUN    = 9'b110101000;
    localparam logic [8:0] V_LU     = 9'b000111000;
    localparam logic [8:0] V_BRANCH = 9'b111111000;
    localparam logic [8:0] V_JUMP   = 9'b111101000;
    localparam logic [8:0] V_FREEZE = 9'b000000110;
    localparam logic [8:0] V_ACKRUN = 9'b110101010;
    localparam logic [8:0] V_ACKBR  = 9'b111111010;
    localparam logic [8:0] V_ERR    = 9'b000000101;

    hazard_stall_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_uses_rt   (id_uses_rt),
        .i_id_jump      (id_jump),
        .i_ex_memread   (ex_memread),
        .i_ex_rt        (ex_rt),
        .i_ex_br_taken  (ex_br_taken),
        .i_mem_access   (mem_access),
        .i_dmem_ack     (dmem_ack),
        .o_pc_en        (pc_en),
        .o_ifid_en      (ifid_en),
        .o_ifid_flush   (ifid_flush),
        .o_idex_en      (idex_en),
        .o_idex_flush   (idex_flush),
        .o_exmem_en     (exmem_en),
        .o_memwb_bubble (memwb_bubble),
        .o_dmem_req     (dmem_req),
        .o_timeout_err  (timeout_err),
        .o_stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_uses_rt  = 1'b0;
        id_jump     = 1'b0;
        ex_memread  = 1'b0;
        ex_rt       = 5'd0;
        ex_br_taken = 1'b0;
        mem_access  = 1'b0;
        dmem_ack    = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        mem_access = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== V_RESET) begin
            errors++;
            $display("FAIL reset_ctl: got %b want %b", ctl, V_RESET);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
        tick();
        tick();
        rst = 1'b0;
        idle();
        exp_stall = 0;
        #1;
        checks++;
        if (ctl !== V_RUN) begin
            errors++;
            $display("FAIL reset_release_ctl: got %b want %b", ctl, V_RUN);
        end
    endtask

    task automatic test_load_use();
        idle();
        ex_memread = 1'b1;
        ex_rt      = 5'd8;
        id_rs      = 5'd8;
        id_rt      = 5'd9;
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if (ctl !== V_LU) begin
            errors++;
            $display("FAIL lu_rs_ctl: got %b want %b", ctl, V_LU);
        end
        tick();
        exp_stall = exp_stall + 1;
        idle();
        #1;
        checks++;
        if (stall_cnt !== 16'(exp_stall) || ctl !== V_RUN) begin
            errors++;
            $display("FAIL lu_after: got cnt=%0d ctl=%b want cnt=%0d ctl=%b", stall_cnt, ctl, exp_stall, V_RUN);
        end
    endtask

    task automatic test_no_stall();
        idle();
        ex_memread = 1'b1;
        ex_rt      = 5'd0;
        id_rs      = 5'd0;
        #1;
        checks++;
        if (ctl !== V_RUN) begin
            errors++;
            $display("FAIL lu_zero_reg: got %b want %b", ctl, V_RUN);
        end
        tick();
        ex_rt      = 5'd8;
        id_rs      = 5'd3;
        id_rt      = 5'd8;
        id_uses_rt = 1'b0;
        #1;
        checks++;
        if (ctl !== V_RUN) begin
            errors++;
            $display("FAIL lu_rt_unused: got %b want %b", ctl, V_RUN);
        end
        tick();
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if (ctl !== V_LU) begin
            errors++;
            $display("FAIL lu_rt_used: got %b want %b", ctl, V_LU);
        end
        tick();
        exp_stall = exp_stall + 1;
        idle();
        #1;
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL no_stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_priority();
        idle();
        ex_memread  = 1'b1;
        ex_rt       = 5'd8;
        id_rs       = 5'd8;
        id_jump     = 1'b1;
        ex_br_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== V_BRANCH) begin
            errors++;
            $display("FAIL br_over_lu_jump: got %b want %b", ctl, V_BRANCH);
        end
        tick();
        ex_br_taken = 1'b0;
        #1;
        checks++;
        if (ctl !== V_LU) begin
            errors++;
            $display("FAIL lu_over_jump: got %b want %b", ctl, V_LU);
        end
        tick();
        exp_stall = exp_stall + 1;
        ex_memread = 1'b0;
        #1;
        checks++;
        if (ctl !== V_JUMP) begin
            errors++;
            $display("FAIL jump_only: got %b want %b", ctl, V_JUMP);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL priority_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_mem_wait();
        idle();
        mem_access  = 1'b1;
        ex_br_taken = 1'b1;
        ex_memread  = 1'b1;
        ex_rt       = 5'd8;
        id_rs       = 5'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl !== V_FREEZE) begin
                errors++;
                $display("FAIL wait3_freeze[%0d]: got %b want %b", i, ctl, V_FREEZE);
            end
            tick();
        end
        exp_stall = exp_stall + 3;
        ex_memread = 1'b0;
        dmem_ack   = 1'b1;
        #1;
        checks++;
        if (ctl !== V_ACKBR) begin
            errors++;
            $display("FAIL wait3_release: got %b want %b", ctl, V_ACKBR);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== V_RUN || stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL wait3_after: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", ctl, stall_cnt, V_RUN, exp_stall);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        mem_access = 1'b1;
        dmem_ack   = 1'b1;
        #1;
        checks++;
        if (ctl !== V_ACKRUN) begin
            errors++;
            $display("FAIL zero_wait: got %b want %b", ctl, V_ACKRUN);
        end
        tick();
        mem_access = 1'b0;
        #1;
        checks++;
        if (ctl !== V_RUN) begin
            errors++;
            $display("FAIL stray_ack: got %b want %b", ctl, V_RUN);
        end
        tick();
        mem_access = 1'b1;
        dmem_ack   = 1'b0;
        #1;
        checks++;
        if (ctl !== V_FREEZE) begin
            errors++;
            $display("FAIL b2b_freeze: got %b want %b", ctl, V_FREEZE);
        end
        tick();
        exp_stall = exp_stall + 1;
        dmem_ack  = 1'b1;
        #1;
        checks++;
        if (ctl !== V_ACKRUN) begin
            errors++;
            $display("FAIL b2b_ack: got %b want %b", ctl, V_ACKRUN);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL b2b_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_timeout_ack();
        idle();
        mem_access = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++;
            if (ctl !== V_FREEZE) begin
                errors++;
                $display("FAIL tack_freeze[%0d]: got %b want %b", i, ctl, V_FREEZE);
            end
            tick();
        end
        exp_stall = exp_stall + 15;
        dmem_ack = 1'b1;
        #1;
        checks++;
        if (ctl !== V_ACKRUN) begin
            errors++;
            $display("FAIL tack_last_cycle: got %b want %b", ctl, V_ACKRUN);
        end
        tick();
        idle();
        #1;
        checks++;
        if (ctl !== V_RUN || stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL tack_after: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", ctl, stall_cnt, V_RUN, exp_stall);
        end
    endtask

    task automatic test_timeout();
        idle();
        mem_access = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (ctl !== V_FREEZE) begin
                errors++;
                $display("FAIL tmo_freeze[%0d]: got %b want %b", i, ctl, V_FREEZE);
            end
            tick();
        end
        exp_stall = exp_stall + 16;
        ex_br_taken = 1'b1;
        id_jump     = 1'b1;
        #1;
        checks++;
        if (ctl !== V_ERR) begin
            errors++;
            $display("FAIL tmo_err_ctl: got %b want %b", ctl, V_ERR);
        end
        tick();
        dmem_ack = 1'b1;
        tick();
        #1;
        checks++;
        if (ctl !== V_ERR || stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL tmo_sticky: got ctl=%b cnt=%0d want ctl=%b cnt=%0d", ctl, stall_cnt, V_ERR, exp_stall);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        exp_stall = 0;
        #1;
        checks++;
        if (ctl !== V_RUN || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL tmo_recover: got ctl=%b cnt=%0d want ctl=%b cnt=0", ctl, stall_cnt, V_RUN);
        end
    endtask

    task automatic test_reset_mid_wait();
        idle();
        mem_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== V_RESET || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_wait: got ctl=%b cnt=%0d want ctl=%b cnt=0", ctl, stall_cnt, V_RESET);
        end
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (ctl !== V_RUN || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_after: got ctl=%b cnt=%0d want ctl=%b cnt=0", ctl, stall_cnt, V_RUN);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack   = 1'b0;
        mem_access = 1'b1;
        #1;
        checks++;
        if (ctl !== V_FREEZE) begin
            errors++;
            $display("FAIL rst_mid_rerequest: got %b want %b", ctl, V_FREEZE);
        end
        tick();
        dmem_ack = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_mid_cnt: got %0d want 1", stall_cnt);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_stall = 0;
        rst       = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_no_stall();
        test_priority();
        test_mem_wait();
        test_back_to_back();
        test_timeout_ack();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
